// File: rtl/mem_master_pkg.sv
// Shared encodings for the MEM initiator.
// Command codes, FSM states and default widths.
package mem_master_pkg;

   localparam int WORDSIZE_DEF   = 8;
   localparam int ADDR_WIDTH_DEF = 9;
   localparam int LEN_WIDTH_DEF  = 9;

   typedef enum logic [1:0] {
      CMD_RD   = 2'b00,
      CMD_WR   = 2'b01,
      CMD_FILL = 2'b10,
      CMD_ILL  = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RD_CAP,
      S_WR,
      S_FILL,
      S_RESP
   } state_e;

endpackage

// File: rtl/mem_master_addr_gen.sv
// Address register with wrapping increment and
// a down-counter of remaining fill words.
module mem_master_addr_gen #(
   parameter int AW = 9,
   parameter int LW = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step,
   input  logic [AW-1:0] addr_in,
   input  logic [LW-1:0] cnt_in,
   output logic [AW-1:0] addr,
   output logic          zero
);

   logic [LW-1:0] cnt;

   // load on accept, then advance one word per fill cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
         cnt  <= '0;
      end else if (load) begin
         addr <= addr_in;
         cnt  <= cnt_in;
      end else if (step) begin
         addr <= addr + AW'(1);
         cnt  <= cnt - LW'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_master.sv
// Sequencing initiator for the MEM word RAM.
// Read, write and fill requests in; one response out.
module mem_master
   import mem_master_pkg::*;
#(
   parameter int WORDSIZE   = WORDSIZE_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_cmd,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WORDSIZE-1:0]   req_wdata,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WORDSIZE-1:0]   rsp_data,
   output logic                  rsp_err,
   output logic                  mem_enable,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [WORDSIZE-1:0]   mem_data_in,
   input  logic [WORDSIZE-1:0]   mem_data_out
);

   state_e state;
   logic   ag_load;
   logic   ag_step;
   logic   ag_zero;
   logic [LEN_WIDTH-1:0] cnt_init;

   // counter holds words left after the current one
   assign cnt_init = req_len - LEN_WIDTH'(1);
   assign ag_load  = (state == S_IDLE) && req_valid;
   assign ag_step  = (state == S_FILL) && !ag_zero;

   mem_master_addr_gen #(
      .AW (ADDR_WIDTH),
      .LW (LEN_WIDTH)
   ) u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ag_load),
      .step    (ag_step),
      .addr_in (req_addr),
      .cnt_in  (cnt_init),
      .addr    (mem_address),
      .zero    (ag_zero)
   );

   // request sequencer with registered strobes and response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         mem_enable  <= 1'b0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
         mem_data_in <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req_valid) begin
                  req_ready   <= 1'b0;
                  mem_data_in <= req_wdata;
                  unique case (cmd_e'(req_cmd))
                     CMD_RD: begin
                        state      <= S_RD;
                        mem_enable <= 1'b1;
                        mem_re     <= 1'b1;
                     end
                     CMD_WR: begin
                        state      <= S_WR;
                        mem_enable <= 1'b1;
                        mem_we     <= 1'b1;
                     end
                     CMD_FILL: begin
                        if (req_len != '0) begin
                           state      <= S_FILL;
                           mem_enable <= 1'b1;
                           mem_we     <= 1'b1;
                        end else begin
                           state     <= S_RESP;
                           rsp_valid <= 1'b1;
                        end
                     end
                     CMD_ILL: begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                     end
                  endcase
               end
            end
            S_RD: begin
               state      <= S_RD_CAP;
               mem_enable <= 1'b0;
               mem_re     <= 1'b0;
            end
            S_RD_CAP: begin
               state     <= S_RESP;
               rsp_data  <= mem_data_out;
               rsp_valid <= 1'b1;
            end
            S_WR: begin
               state      <= S_RESP;
               mem_enable <= 1'b0;
               mem_we     <= 1'b0;
               rsp_valid  <= 1'b1;
            end
            S_FILL: begin
               if (ag_zero) begin
                  state      <= S_RESP;
                  mem_enable <= 1'b0;
                  mem_we     <= 1'b0;
                  rsp_valid  <= 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_data  <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_master.sv
// Randomized bench for mem_master with a word RAM
// model and an array-based reference of memory contents.
module tb_mem_master;

   localparam int AW = 9;
   localparam int DW = 8;
   localparam int LW = 9;
   localparam int NW = 512;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_cmd = 2'b00;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [LW-1:0] req_len = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          mem_enable;
   logic          mem_we;
   logic          mem_re;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;

   int total = 0;
   int bad = 0;

   mem_master dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_cmd      (req_cmd),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_len      (req_len),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .mem_enable   (mem_enable),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram [NW];
   logic [DW-1:0] ref_mem [NW];

   // MEM model: synchronous write and registered read port
   always @(posedge clk) begin
      if (mem_enable && mem_we) ram[mem_address] <= mem_data_in;
      if (mem_enable && mem_re) mem_data_out <= ram[mem_address];
   end

   int cyc = 0;
   int we_cnt = 0;
   int re_cnt = 0;
   int both_cnt = 0;
   int en_bad = 0;
   int rsp_hi = 0;
   logic [AW-1:0] wq_addr [$];
   logic [DW-1:0] wq_data [$];
   int            wq_cyc [$];

   // strobe monitor sampled mid-cycle
   always @(negedge clk) begin
      cyc++;
      if (mem_we) begin
         we_cnt++;
         wq_addr.push_back(mem_address);
         wq_data.push_back(mem_data_in);
         wq_cyc.push_back(cyc);
      end
      if (mem_re) re_cnt++;
      if (mem_we && mem_re) both_cnt++;
      if (mem_enable !== (mem_we | mem_re)) en_bad++;
      if (rsp_valid) rsp_hi++;
   end

   task automatic clr_mon();
      we_cnt = 0;
      re_cnt = 0;
      wq_addr.delete();
      wq_data.delete();
      wq_cyc.delete();
   endtask

   // edges after accept at which rsp_valid is first present
   function automatic int exp_lat(input logic [1:0] c, input int len);
      case (c)
         2'b00:   return 3;
         2'b01:   return 2;
         2'b10:   return (len == 0) ? 1 : len + 1;
         default: return 1;
      endcase
   endfunction

   function automatic void ref_apply(input logic [1:0] c, input int a,
                                     input logic [DW-1:0] d, input int len);
      if (c == 2'b01) ref_mem[a] = d;
      if (c == 2'b10)
         for (int i = 0; i < len; i++) ref_mem[(a + i) % NW] = d;
   endfunction

   task automatic do_req(input logic [1:0] c, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [LW-1:0] len,
                         input int stall, output logic [DW-1:0] data,
                         output logic err, output int lat,
                         output logic stable);
      req_cmd   = c;
      req_addr  = a;
      req_wdata = d;
      req_len   = len;
      req_valid = 1'b1;
      rsp_ready = (stall == 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 1000) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!rsp_valid) begin
         lat = -1;
         data = 'x;
         err = 1'bx;
         stable = 1'b0;
         rsp_ready = 1'b1;
         return;
      end
      data = rsp_data;
      err = rsp_err;
      stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         if (!rsp_valid || rsp_data !== data || rsp_err !== err ||
             req_ready || mem_enable)
            stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      req_valid = 1'b1;
      req_cmd   = 2'b01;
      req_addr  = 9'h030;
      req_wdata = 8'hEE;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({req_ready, rsp_valid, rsp_err, mem_enable, mem_we, mem_re} !== 6'b100000) begin
         bad++;
         $display("FAIL reset_ctrl got %b want 100000",
                  {req_ready, rsp_valid, rsp_err, mem_enable, mem_we, mem_re});
      end
      total++;
      if ({rsp_data, mem_address, mem_data_in} !== '0) begin
         bad++;
         $display("FAIL reset_bus got %h %h %h want 0", rsp_data, mem_address, mem_data_in);
      end
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 1'b0;
      clr_mon();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (we_cnt !== 0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_req_ignored got we=%0d rdy=%b want 0 1", we_cnt, req_ready);
      end
   endtask

   task automatic test_write_read();
      logic [DW-1:0] d;
      logic e, s;
      int lat;
      clr_mon();
      do_req(2'b01, 9'h010, 8'hA5, '0, 0, d, e, lat, s);
      ref_apply(2'b01, 'h010, 8'hA5, 0);
      total++;
      if (lat !== 2 || e !== 1'b0 || d !== 8'h00) begin
         bad++;
         $display("FAIL wr_rsp got lat=%0d err=%b d=%h want 2 0 00", lat, e, d);
      end
      total++;
      if (we_cnt !== 1 || re_cnt !== 0 || wq_addr.size() != 1) begin
         bad++;
         $display("FAIL wr_strobes got we=%0d re=%0d want 1 0", we_cnt, re_cnt);
      end else begin
         total++;
         if (wq_addr[0] !== 9'h010 || wq_data[0] !== 8'hA5) begin
            bad++;
            $display("FAIL wr_bus got %h/%h want 010/a5", wq_addr[0], wq_data[0]);
         end
      end
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL wr_idle got v=%b r=%b want 0 1", rsp_valid, req_ready);
      end
      clr_mon();
      do_req(2'b00, 9'h010, 8'h00, '0, 0, d, e, lat, s);
      total++;
      if (lat !== 3 || e !== 1'b0 || d !== 8'hA5) begin
         bad++;
         $display("FAIL rd_rsp got lat=%0d err=%b d=%h want 3 0 a5", lat, e, d);
      end
      total++;
      if (we_cnt !== 0 || re_cnt !== 1) begin
         bad++;
         $display("FAIL rd_strobes got we=%0d re=%0d want 0 1", we_cnt, re_cnt);
      end
   endtask

   task automatic test_fill_wrap();
      logic [DW-1:0] d;
      logic e, s;
      int lat;
      int a;
      clr_mon();
      do_req(2'b10, 9'h1FE, 8'h3C, 9'd4, 0, d, e, lat, s);
      ref_apply(2'b10, 'h1FE, 8'h3C, 4);
      total++;
      if (lat !== 5 || e !== 1'b0 || we_cnt !== 4) begin
         bad++;
         $display("FAIL fill_rsp got lat=%0d err=%b we=%0d want 5 0 4", lat, e, we_cnt);
      end
      for (int i = 0; i < wq_addr.size() && i < 4; i++) begin
         a = ('h1FE + i) % NW;
         total++;
         if (wq_addr[i] !== AW'(a) || wq_data[i] !== 8'h3C ||
             wq_cyc[i] !== wq_cyc[0] + i) begin
            bad++;
            $display("FAIL fill_word%0d got %h/%h c%0d want %h/3c c%0d",
                     i, wq_addr[i], wq_data[i], wq_cyc[i], a, wq_cyc[0] + i);
         end
      end
      for (int i = 0; i < 5; i++) begin
         a = ('h1FE + i) % NW;
         do_req(2'b00, AW'(a), 8'h00, '0, 0, d, e, lat, s);
         total++;
         if (d !== ref_mem[a]) begin
            bad++;
            $display("FAIL fill_rd %h got %h want %h", a, d, ref_mem[a]);
         end
      end
   endtask

   task automatic test_len0_illegal();
      logic [DW-1:0] d;
      logic e, s;
      int lat;
      clr_mon();
      do_req(2'b10, 9'h055, 8'h99, 9'd0, 0, d, e, lat, s);
      total++;
      if (lat !== 1 || e !== 1'b0 || we_cnt + re_cnt !== 0) begin
         bad++;
         $display("FAIL fill0 got lat=%0d err=%b str=%0d want 1 0 0", lat, e, we_cnt + re_cnt);
      end
      clr_mon();
      do_req(2'b11, 9'h066, 8'h77, 9'd3, 0, d, e, lat, s);
      total++;
      if (lat !== 1 || e !== 1'b1 || d !== 8'h00 || we_cnt + re_cnt !== 0) begin
         bad++;
         $display("FAIL illegal got lat=%0d err=%b d=%h str=%0d want 1 1 00 0",
                  lat, e, d, we_cnt + re_cnt);
      end
      total++;
      if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL illegal_clr got err=%b v=%b want 0 0", rsp_err, rsp_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] d;
      logic e, s;
      int lat;
      do_req(2'b01, 9'h0A0, 8'h5A, '0, 0, d, e, lat, s);
      ref_apply(2'b01, 'h0A0, 8'h5A, 0);
      clr_mon();
      do_req(2'b00, 9'h0A0, 8'h00, '0, 10, d, e, lat, s);
      total++;
      if (s !== 1'b1 || d !== 8'h5A || lat !== 3) begin
         bad++;
         $display("FAIL bp_hold got stable=%b d=%h lat=%0d want 1 5a 3", s, d, lat);
      end
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || re_cnt !== 1) begin
         bad++;
         $display("FAIL bp_release got v=%b r=%b re=%0d want 0 1 1", rsp_valid, req_ready, re_cnt);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] d, wd, exp_d;
      logic e, s;
      logic [1:0] c;
      logic [AW-1:0] a;
      int lat, len, stall, ew, er;
      for (int n = 0; n < 40; n++) begin
         c     = 2'($urandom_range(0, 3));
         a     = AW'($urandom_range(0, NW - 1));
         wd    = DW'($urandom);
         len   = $urandom_range(0, 6);
         stall = $urandom_range(0, 3);
         exp_d = (c == 2'b00) ? ref_mem[a] : 8'h00;
         ew    = (c == 2'b01) ? 1 : (c == 2'b10) ? len : 0;
         er    = (c == 2'b00) ? 1 : 0;
         clr_mon();
         do_req(c, a, wd, LW'(len), stall, d, e, lat, s);
         ref_apply(c, int'(a), wd, len);
         total++;
         if (d !== exp_d || e !== (c == 2'b11) || lat !== exp_lat(c, len) ||
             s !== 1'b1 || we_cnt !== ew || re_cnt !== er) begin
            bad++;
            $display("FAIL rand%0d c=%0d a=%h got d=%h e=%b lat=%0d s=%b we=%0d re=%0d want %h %b %0d 1 %0d %0d",
                     n, c, a, d, e, lat, s, we_cnt, re_cnt,
                     exp_d, c == 2'b11, exp_lat(c, len), ew, er);
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      logic [DW-1:0] d;
      logic e, s;
      int lat, hi0;
      do_req(2'b01, 9'h024, 8'h77, '0, 0, d, e, lat, s);
      ref_apply(2'b01, 'h024, 8'h77, 0);
      clr_mon();
      req_cmd   = 2'b10;
      req_addr  = 9'h020;
      req_wdata = 8'hC3;
      req_len   = 9'd8;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      hi0 = rsp_hi;
      rst_n = 1'b0;
      #1;
      total++;
      if ({mem_enable, mem_we, mem_re, rsp_valid, req_ready} !== 5'b00001) begin
         bad++;
         $display("FAIL rst_async got %b want 00001",
                  {mem_enable, mem_we, mem_re, rsp_valid, req_ready});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      ref_apply(2'b10, 'h020, 8'hC3, 3);
      total++;
      if (rsp_hi !== hi0 || req_ready !== 1'b1 || we_cnt !== 3) begin
         bad++;
         $display("FAIL rst_fill got rsp=%0d rdy=%b we=%0d want %0d 1 3",
                  rsp_hi - hi0, req_ready, we_cnt, 0);
      end
      for (int i = 0; i < 8; i++) begin
         do_req(2'b00, AW'('h020 + i), 8'h00, '0, 0, d, e, lat, s);
         total++;
         if (d !== ref_mem['h020 + i]) begin
            bad++;
            $display("FAIL rst_fill_rd %h got %h want %h", 'h020 + i, d, ref_mem['h020 + i]);
         end
      end
   endtask

   task automatic test_protocol();
      total++;
      if (both_cnt !== 0 || en_bad !== 0) begin
         bad++;
         $display("FAIL strobe_rules got both=%0d en_bad=%0d want 0 0", both_cnt, en_bad);
      end
   endtask

   initial begin
      for (int i = 0; i < NW; i++) begin
         ram[i] = '0;
         ref_mem[i] = '0;
      end
      mem_data_out = '0;
      test_reset();
      test_write_read();
      test_fill_wrap();
      test_len0_illegal();
      test_backpressure();
      test_random();
      test_reset_mid_fill();
      test_protocol();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
